// File: rtl/strobe_tracker.sv
// strobe_tracker: samples a slow strobe, emits one-cycle ticks, measures
// its period, locks on a stable period and tracks a radix-4 phase index.
module strobe_tracker #(
  parameter int PERIOD_W   = 6,
  parameter int LOCK_COUNT = 4,
  parameter int TOL        = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                strobe_in,
  output logic                tick,
  output logic [1:0]          phase,
  output logic [PERIOD_W-1:0] period,
  output logic                locked,
  output logic                lost
);

  localparam int MW = $clog2(LOCK_COUNT + 1);

  localparam logic [PERIOD_W-1:0] CNT_MAX = '1;
  localparam logic [PERIOD_W:0]   TOL_X   = (PERIOD_W + 1)'(TOL);
  localparam logic [MW-1:0]       LOCK_N  = MW'(LOCK_COUNT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRAIN,
    S_LOCKED
  } state_t;

  state_t              r_state;
  logic                r_strobe_d;
  logic [PERIOD_W-1:0] r_cnt;
  logic [PERIOD_W-1:0] r_ref;
  logic [MW-1:0]       r_match;
  logic                r_tick;
  logic [1:0]          r_phase;
  logic [PERIOD_W-1:0] r_period;
  logic                r_locked;
  logic                r_lost;

  logic                w_rise;
  logic [PERIOD_W:0]   w_cnt_x;
  logic [PERIOD_W:0]   w_ref_x;
  logic [PERIOD_W:0]   w_diff;
  logic                w_in_tol;
  logic                w_sat;
  logic                w_wd;
  logic [PERIOD_W-1:0] w_ref_nxt;
  logic [MW-1:0]       w_match_nxt;
  logic                w_lock_hit;

  assign w_rise = strobe_in & ~r_strobe_d;

  // One extra bit so ref+TOL and the distance never wrap.
  assign w_cnt_x = {1'b0, r_cnt};
  assign w_ref_x = {1'b0, r_ref};
  assign w_diff  = (w_cnt_x >= w_ref_x) ? (w_cnt_x - w_ref_x)
                                        : (w_ref_x - w_cnt_x);

  assign w_in_tol = (w_diff <= TOL_X);
  assign w_sat    = (r_cnt == CNT_MAX);
  assign w_wd     = (w_cnt_x >= (w_ref_x + TOL_X));

  // Training update: a saturated count wipes the reference, a matching
  // period extends the streak, anything else starts a new streak.
  always_comb begin
    w_ref_nxt   = r_cnt;
    w_match_nxt = MW'(1);
    if (w_sat) begin
      w_ref_nxt   = '0;
      w_match_nxt = '0;
    end else if ((r_match != '0) && w_in_tol) begin
      w_ref_nxt   = r_ref;
      w_match_nxt = r_match + MW'(1);
    end
  end

  assign w_lock_hit = (w_match_nxt == LOCK_N);

  // Edge detect, tick pulse and saturating edge-to-edge counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_strobe_d <= 1'b0;
      r_tick     <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_strobe_d <= strobe_in;
      r_tick     <= w_rise;
      if (w_rise) begin
        r_cnt <= PERIOD_W'(1);
      end else if (!w_sat) begin
        r_cnt <= r_cnt + PERIOD_W'(1);
      end
    end
  end

  // Lock FSM with registered period, phase, locked and lost outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ref    <= '0;
      r_match  <= '0;
      r_phase  <= 2'd0;
      r_period <= '0;
      r_locked <= 1'b0;
      r_lost   <= 1'b0;
    end else begin
      r_lost <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_state <= S_TRAIN;
          end
        end
        S_TRAIN: begin
          if (w_rise) begin
            if (r_cnt != '0) begin
              r_period <= r_cnt;
            end
            r_ref   <= w_ref_nxt;
            r_match <= w_match_nxt;
            if (w_lock_hit) begin
              r_state  <= S_LOCKED;
              r_locked <= 1'b1;
              r_phase  <= 2'd0;
            end
          end
        end
        S_LOCKED: begin
          if (w_rise) begin
            if (r_cnt != '0) begin
              r_period <= r_cnt;
            end
            if (w_in_tol) begin
              r_phase <= r_phase + 2'd1;
            end else begin
              r_lost   <= 1'b1;
              r_locked <= 1'b0;
              r_phase  <= 2'd0;
              r_ref    <= r_cnt;
              r_match  <= MW'(1);
              r_state  <= S_TRAIN;
            end
          end else if (w_wd) begin
            r_lost   <= 1'b1;
            r_locked <= 1'b0;
            r_phase  <= 2'd0;
            r_match  <= '0;
            r_state  <= S_TRAIN;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tick   = r_tick;
  assign phase  = r_phase;
  assign period = r_period;
  assign locked = r_locked;
  assign lost   = r_lost;

endmodule
